// File: rtl/wb_sdr_arbiter.sv
`default_nettype none
// wb_sdr_arbiter (rev 1.0): round-robin Wishbone arbiter for the sdrc_top slave port.
// A grant spans a whole cyc tenure. An idle-stall watchdog reclaims the port.
module wb_sdr_arbiter #(
    parameter int NUM_M    = 4,
    parameter int APP_AW   = 26,
    parameter int DW       = 32,
    parameter int BW       = 4,
    parameter int IDLE_MAX = 16
) (
    input  logic                  sys_clk,
    input  logic                  resetn,
    input  logic [NUM_M-1:0]      m_cyc_i,
    input  logic [NUM_M-1:0]      m_stb_i,
    input  logic [NUM_M-1:0]      m_we_i,
    input  logic [NUM_M*APP_AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0]   m_dat_i,
    input  logic [NUM_M*BW-1:0]   m_sel_i,
    input  logic [NUM_M*3-1:0]    m_cti_i,
    output logic [DW-1:0]         m_dat_o,
    output logic [NUM_M-1:0]      m_ack_o,
    output logic [NUM_M-1:0]      m_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [APP_AW-1:0]     s_addr_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [BW-1:0]         s_sel_o,
    output logic [2:0]            s_cti_o,
    input  logic [DW-1:0]         s_dat_i,
    input  logic                  s_ack_i,
    output logic [NUM_M-1:0]      grant_o,
    output logic                  busy_o
);

    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [NUM_M-1:0] grant, grant_nxt;
    logic [NUM_M-1:0] lock, lock_nxt;
    logic [IW-1:0]    gidx, gidx_nxt;
    logic [IW-1:0]    ptr, ptr_nxt;
    logic [7:0]       wcnt, wcnt_nxt;

    logic [NUM_M-1:0] req;
    logic [IW:0]      scan;
    logic [IW-1:0]    sel;
    logic             sel_found;
    logic             g_cyc, g_stb;
    logic             stall, abort;

    assign req   = m_cyc_i & m_stb_i & ~lock;
    assign g_cyc = |(m_cyc_i & grant);
    assign g_stb = |(m_stb_i & grant);
    assign stall = (state == BUSY) && g_cyc && !g_stb && !s_ack_i;
    assign abort = stall && (wcnt == 8'(IDLE_MAX - 1));

    // Scan upward from ptr+1; the last candidate is ptr itself, so a lone
    // requester can be re-granted right after its own release.
    always_comb begin
        scan      = '0;
        sel       = ptr;
        sel_found = 1'b0;
        for (int i = 1; i <= NUM_M; i++) begin
            scan = {1'b0, ptr} + (IW+1)'(i);
            if (scan >= (IW+1)'(NUM_M))
                scan = scan - (IW+1)'(NUM_M);
            if (!sel_found && req[scan[IW-1:0]]) begin
                sel       = scan[IW-1:0];
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        gidx_nxt  = gidx;
        ptr_nxt   = ptr;
        wcnt_nxt  = 8'd0;
        lock_nxt  = lock & m_cyc_i;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = BUSY;
                    grant_nxt = {{(NUM_M-1){1'b0}}, 1'b1} << sel;
                    gidx_nxt  = sel;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = gidx;
                end else if (abort) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = gidx;
                    lock_nxt  = lock_nxt | grant;
                end else if (stall) begin
                    wcnt_nxt = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            state <= IDLE;
            grant <= '0;
            lock  <= '0;
            gidx  <= '0;
            ptr   <= IW'(NUM_M - 1);
            wcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            lock  <= lock_nxt;
            gidx  <= gidx_nxt;
            ptr   <= ptr_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Slave-side mux and master-side routing; everything is quiet outside BUSY.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cti_o  = 3'b000;
        m_ack_o  = '0;
        m_err_o  = '0;
        if (state == BUSY) begin
            s_cyc_o = g_cyc;
            s_stb_o = g_stb;
            for (int k = 0; k < NUM_M; k++) begin
                if (grant[k]) begin
                    s_we_o   = m_we_i[k];
                    s_addr_o = m_addr_i[k*APP_AW +: APP_AW];
                    s_dat_o  = m_dat_i[k*DW +: DW];
                    s_sel_o  = m_sel_i[k*BW +: BW];
                    s_cti_o  = m_cti_i[k*3 +: 3];
                end
            end
            m_ack_o = grant & {NUM_M{s_ack_i}};
            if (abort)
                m_err_o = grant;
        end
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = grant;
    assign busy_o  = (state == BUSY);

endmodule
`default_nettype wire
